sp_ram_arb: RTL and testbench

- Request front-end placed directly upstream of the single-port RAM wrapper.
- Accepts independent write and read requests over valid/ready handshakes and arbitrates them onto the RAM's single port.
- Tracks read latency and buffers read data in a response queue with valid/ready output.
- Uses credit-based read issue, so a response is never dropped under back-pressure.

---
 rtl/sp_ram_arb_pkg.sv | 35 +++
 rtl/s_fflopnx.sv | 32 +++
 rtl/sp_ram_rspq.sv | 66 ++++++
 rtl/sp_ram_arb.sv | 128 ++++++++++++
 tb/tb_sp_ram_arb.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sp_ram_arb_pkg.sv
// Shared defaults for the single-port RAM front-end and the RAM wrapper behind it.
// Latency: n/a (types, constants and a pure arbitration helper only).
// Backpressure: n/a.
package sp_ram_arb_pkg;

    // Widths and read latency shared with the RAM wrapper so both agree on timing.
    localparam int C_ADDR_W    = 10;
    localparam int C_DATA_W    = 16;
    localparam int C_PIPELINE  = 1;
    localparam int C_RDQ_DEPTH = C_PIPELINE + 1;
    localparam int C_RDQ_AW    = 4;

    // Which requester owns the RAM port this cycle.
    typedef enum logic [1:0] {
        GNT_IDLE = 2'd0,
        GNT_WR   = 2'd1,
        GNT_RD   = 2'd2
    } gnt_e;

    // Single-grant arbitration: a lone eligible side wins; on conflict rr picks
    // (rr=0 favours the write, rr=1 favours the read).
    function automatic gnt_e rr_pick(input logic wr_elig,
                                     input logic rd_elig,
                                     input logic rr);
        gnt_e g;
        g = GNT_IDLE;
        if (wr_elig && (!rd_elig || !rr)) begin
            g = GNT_WR;
        end else if (rd_elig) begin
            g = GNT_RD;
        end
        return g;
    endfunction

endpackage

// File: rtl/s_fflopnx.sv
// Reset-clearable N-stage flop chain (delay line) of W-bit words.
// Latency: N cycles from d to q.
// Backpressure: none; shifts every cycle.
module s_fflopnx #(
    parameter int W = 1,
    parameter int N = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] stg [N];

    // Shift the chain every cycle; reset clears every stage at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                stg[i] <= '0;
            end
        end else begin
            stg[0] <= d;
            for (int i = 1; i < N; i++) begin
                stg[i] <= stg[i-1];
            end
        end
    end

    assign q = stg[N-1];

endmodule

// File: rtl/sp_ram_rspq.sv
// Register FIFO for read responses, first-word fall-through (head visible while vld).
// Latency: push to vld is 1 cycle; pop takes effect at the clock edge.
// Backpressure: vld held until pop; push while full is dropped (prevented upstream by credits).
module sp_ram_rspq #(
    parameter int W     = 16,
    parameter int DEPTH = 2,
    parameter int AW    = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic         vld,
    output logic [W-1:0] dat
);

    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);

    // Sized to the full pointer range so any pointer value indexes cleanly.
    logic [W-1:0]  mem [2**AW];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == CNT_FULL);
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && (count != '0);
    assign vld     = (count != '0);
    assign dat     = mem[rd_ptr];

    // Storage write; data needs no reset since vld gates its use.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers wrap at DEPTH-1 and the occupancy count tracks push/pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_ONE;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sp_ram_arb.sv
// Write/read request front-end for a single-port RAM with in-order read response queue.
// Latency: grant is combinational; read accept to rsp_vld is G_PIPELINE+1 cycles (empty queue).
// Backpressure: reads are credit-limited to queue space, so rsp_rdy low stalls reads, never drops data.
module sp_ram_arb
    import sp_ram_arb_pkg::*;
#(
    parameter int G_ADDR      = C_ADDR_W,
    parameter int G_WIDTH     = C_DATA_W,
    parameter int G_PIPELINE  = C_PIPELINE,
    parameter int G_RDQ_DEPTH = G_PIPELINE + 1,
    parameter int G_RDQ_AW    = C_RDQ_AW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clrrdy,
    input  logic               wr_vld,
    output logic               wr_rdy,
    input  logic [G_ADDR-1:0]  wr_addr,
    input  logic [G_WIDTH-1:0] wr_dat,
    input  logic               rd_vld,
    output logic               rd_rdy,
    input  logic [G_ADDR-1:0]  rd_addr,
    output logic               ram_we,
    output logic [G_ADDR-1:0]  ram_addr,
    output logic [G_WIDTH-1:0] ram_din,
    input  logic [G_WIDTH-1:0] ram_dout,
    output logic               rsp_vld,
    input  logic               rsp_rdy,
    output logic [G_WIDTH-1:0] rsp_dat
);

    localparam logic [G_RDQ_AW:0] CRED_INIT = (G_RDQ_AW+1)'(G_RDQ_DEPTH);
    localparam logic [G_RDQ_AW:0] CRED_ONE  = (G_RDQ_AW+1)'(1);

    logic [G_RDQ_AW:0]  cred;
    logic               rr;
    logic [G_ADDR-1:0]  addr_q;
    logic               wr_elig;
    logic               rd_elig;
    gnt_e               gnt;
    logic               wr_gnt;
    logic               rd_gnt;
    logic               rd_tail;
    logic               rsp_pop;

    // Eligibility and one-grant-per-cycle arbitration.
    always_comb begin
        wr_elig = clrrdy && wr_vld;
        rd_elig = clrrdy && rd_vld && (cred != '0);
        gnt     = rr_pick(wr_elig, rd_elig, rr);
    end

    assign wr_gnt  = (gnt == GNT_WR);
    assign rd_gnt  = (gnt == GNT_RD);
    assign wr_rdy  = wr_gnt;
    assign rd_rdy  = rd_gnt;
    assign rsp_pop = rsp_vld && rsp_rdy;

    // RAM port drive; when idle the address holds so the RAM sees no spurious change.
    always_comb begin
        ram_we   = 1'b0;
        ram_addr = addr_q;
        ram_din  = wr_dat;
        if (wr_gnt) begin
            ram_we   = 1'b1;
            ram_addr = wr_addr;
        end else if (rd_gnt) begin
            ram_addr = rd_addr;
        end
    end

    // Remember the last driven address for idle cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
        end else if (wr_gnt || rd_gnt) begin
            addr_q <= ram_addr;
        end
    end

    // Round-robin flag flips only when both sides contend.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr <= 1'b0;
        end else if (wr_elig && rd_elig) begin
            rr <= ~rr;
        end
    end

    // Credits count free queue slots not yet promised to an in-flight read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cred <= CRED_INIT;
        end else begin
            case ({rd_gnt, rsp_pop})
                2'b10:   cred <= cred - CRED_ONE;
                2'b01:   cred <= cred + CRED_ONE;
                default: cred <= cred;
            endcase
        end
    end

    // Marks the cycle in which ram_dout carries each issued read's data.
    s_fflopnx #(
        .W (1),
        .N (G_PIPELINE)
    ) u_rd_pipe (
        .clk (clk),
        .rst (rst),
        .d   (rd_gnt),
        .q   (rd_tail)
    );

    sp_ram_rspq #(
        .W     (G_WIDTH),
        .DEPTH (G_RDQ_DEPTH),
        .AW    (G_RDQ_AW)
    ) u_rspq (
        .clk      (clk),
        .rst      (rst),
        .push     (rd_tail),
        .push_dat (ram_dout),
        .pop      (rsp_pop),
        .vld      (rsp_vld),
        .dat      (rsp_dat)
    );

endmodule

// File: tb/tb_sp_ram_arb.sv
module tb_sp_ram_arb;

    localparam int AW    = 10;
    localparam int DW    = 16;
    localparam int PL    = 2;
    localparam int DEPTH = 3;
    localparam int QAW   = 4;

    logic          clk;
    logic          rst;
    logic          clrrdy;
    logic          wr_vld;
    logic          wr_rdy;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_dat;
    logic          rd_vld;
    logic          rd_rdy;
    logic [AW-1:0] rd_addr;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;
    logic          rsp_vld;
    logic          rsp_rdy;
    logic [DW-1:0] rsp_dat;

    int n_chk;
    int n_pass;
    int ovf_cnt;

    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] shadow [1024];
    logic [DW-1:0] mem    [1024];
    logic [DW-1:0] rpipe  [PL];

    sp_ram_arb #(
        .G_ADDR      (AW),
        .G_WIDTH     (DW),
        .G_PIPELINE  (PL),
        .G_RDQ_DEPTH (DEPTH),
        .G_RDQ_AW    (QAW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .clrrdy   (clrrdy),
        .wr_vld   (wr_vld),
        .wr_rdy   (wr_rdy),
        .wr_addr  (wr_addr),
        .wr_dat   (wr_dat),
        .rd_vld   (rd_vld),
        .rd_rdy   (rd_rdy),
        .rd_addr  (rd_addr),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_dout (ram_dout),
        .rsp_vld  (rsp_vld),
        .rsp_rdy  (rsp_rdy),
        .rsp_dat  (rsp_dat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAM model with PL cycles from address to data.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        rpipe[0] <= mem[ram_addr];
        for (int i = 1; i < PL; i++) rpipe[i] <= rpipe[i-1];
    end
    assign ram_dout = rpipe[PL-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Scoreboard: accepted writes update the model, accepted reads queue the
    // expected data, and every popped response is compared in order.
    always @(negedge clk) begin
        if (!rst) begin
            if (wr_vld && wr_rdy) shadow[wr_addr] = wr_dat;
            if (rd_vld && rd_rdy) exp_q.push_back(shadow[rd_addr]);
            if (rsp_vld && rsp_rdy) begin
                chk("rsp_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) chk("rsp_dat", 32'(rsp_dat), 32'(exp_q.pop_front()));
            end
            if (dut.u_rspq.push && dut.u_rspq.full) ovf_cnt++;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        cyc();
        wr_vld  = 1'b0;
        rd_vld  = 1'b0;
        rsp_rdy = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int wi, ri, nacc, stale;
        logic exp_bp [6];
        n_chk = 0; n_pass = 0; ovf_cnt = 0;
        for (int a = 0; a < 1024; a++) begin
            mem[a] = '0;
            shadow[a] = '0;
        end
        for (int i = 0; i < PL; i++) rpipe[i] = '0;
        rst = 1'b1; clrrdy = 1'b0; wr_vld = 1'b0; rd_vld = 1'b0; rsp_rdy = 1'b0;
        wr_addr = '0; wr_dat = '0; rd_addr = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_wr_rdy", 32'(wr_rdy), 32'd0);
        chk("rst_rd_rdy", 32'(rd_rdy), 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_rsp_vld", 32'(rsp_vld), 32'd0);
        cyc();
        rst = 1'b0;

        // Write 0x3A5C to 5, read it back next cycle
        cyc();
        clrrdy = 1'b1; rsp_rdy = 1'b1;
        wr_vld = 1'b1; wr_addr = 10'd5; wr_dat = 16'h3A5C;
        @(negedge clk);
        chk("t1_wr_rdy", 32'(wr_rdy), 32'd1);
        chk("t1_ram_we", 32'(ram_we), 32'd1);
        chk("t1_ram_addr_w", 32'(ram_addr), 32'd5);
        chk("t1_ram_din", 32'(ram_din), 32'h3A5C);
        cyc();
        wr_vld = 1'b0; rd_vld = 1'b1; rd_addr = 10'd5;
        @(negedge clk);
        chk("t1_rd_rdy", 32'(rd_rdy), 32'd1);
        chk("t1_ram_we_r", 32'(ram_we), 32'd0);
        chk("t1_ram_addr_r", 32'(ram_addr), 32'd5);
        for (int k = 1; k <= 3; k++) begin
            cyc();
            rd_vld = 1'b0; rd_addr = 10'd0; wr_addr = 10'h3FF;
            @(negedge clk);
            chk($sformatf("t1_rsp_vld_c%0d", k), 32'(rsp_vld), 32'(k == 3));
            if (k == 1) begin
                chk("t1_idle_addr_hold", 32'(ram_addr), 32'd5);
                chk("t1_idle_we", 32'(ram_we), 32'd0);
            end
            if (k == 3) chk("t1_rsp_dat", 32'(rsp_dat), 32'h3A5C);
        end

        // Conflict: both sides held; grants alternate W,R,W,R,W,R
        wi = 0; ri = 0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            wr_vld = 1'b1; rd_vld = 1'b1;
            wr_addr = AW'(10 + wi); wr_dat = DW'(16'h1000 + wi);
            rd_addr = AW'(10 + ri);
            @(negedge clk);
            chk($sformatf("arb_wr_%0d", i), 32'(wr_rdy), 32'(i % 2 == 0));
            chk($sformatf("arb_rd_%0d", i), 32'(rd_rdy), 32'(i % 2 == 1));
            if (wr_rdy) wi++;
            if (rd_rdy) ri++;
        end
        drain(6);

        // Preload 20..27 with 0x2000+a
        nacc = 0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            wr_vld = 1'b1; wr_addr = AW'(20 + nacc); wr_dat = DW'(16'h2000 + 20 + nacc);
            @(negedge clk);
            if (wr_rdy) nacc++;
        end
        chk("preload_accepts", 32'(nacc), 32'd8);
        drain(6);

        // Back-pressure: only DEPTH reads accepted while rsp_rdy is low
        ri = 0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            rsp_rdy = 1'b0; rd_vld = 1'b1; rd_addr = AW'(20 + ri);
            @(negedge clk);
            if (rd_rdy) ri++;
        end
        chk("bp_accepts", 32'(ri), 32'd3);
        chk("bp_rd_rdy_low", 32'(rd_rdy), 32'd0);
        chk("bp_rsp_vld", 32'(rsp_vld), 32'd1);
        // Credit returns one cycle after each pop; round trip is PL+2 cycles
        exp_bp[0] = 1'b0; exp_bp[1] = 1'b1; exp_bp[2] = 1'b1;
        exp_bp[3] = 1'b1; exp_bp[4] = 1'b0; exp_bp[5] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc();
            rsp_rdy = 1'b1; rd_addr = AW'(20 + ri);
            @(negedge clk);
            chk($sformatf("bp_resume_%0d", i), 32'(rd_rdy), 32'(exp_bp[i]));
            if (rd_rdy) ri++;
        end
        drain(8);

        // Streaming: a credit is held for PL+1 cycles after accept, so with
        // DEPTH=3 the fourth cycle of every four has no credit
        ri = 0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            rsp_rdy = 1'b1; rd_vld = 1'b1; rd_addr = AW'(20 + (ri % 8));
            @(negedge clk);
            chk($sformatf("stream_rdy_%0d", i), 32'(rd_rdy), 32'(i % 4 != 3));
            if (rd_rdy) ri++;
        end
        drain(8);

        // clrrdy gating
        for (int i = 0; i < 2; i++) begin
            cyc();
            clrrdy = 1'b0; wr_vld = 1'b1; rd_vld = 1'b1;
            wr_addr = 10'd30; wr_dat = 16'hBEEF; rd_addr = 10'd30;
            @(negedge clk);
            chk("clr_wr_rdy", 32'(wr_rdy), 32'd0);
            chk("clr_rd_rdy", 32'(rd_rdy), 32'd0);
            chk("clr_ram_we", 32'(ram_we), 32'd0);
        end
        cyc();
        clrrdy = 1'b1;
        @(negedge clk);
        chk("clr_first_wr", 32'(wr_rdy), 32'd1);
        chk("clr_first_we", 32'(ram_we), 32'd1);
        cyc();
        wr_vld = 1'b0;
        @(negedge clk);
        chk("clr_then_rd", 32'(rd_rdy), 32'd1);
        cyc();
        rd_vld = 1'b0; clrrdy = 1'b0;
        repeat (5) @(negedge clk);
        chk("clr_inflight_drained", 32'(exp_q.size()), 32'd0);
        cyc();
        clrrdy = 1'b1;
        drain(4);

        // Reset with 2 reads in flight and 1 queued
        ri = 0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            rsp_rdy = 1'b0; rd_vld = 1'b1; rd_addr = AW'(20 + ri);
            @(negedge clk);
            if (rd_rdy) ri++;
        end
        chk("rst_mid_accepts", 32'(ri), 32'd3);
        cyc();
        rd_vld = 1'b0;
        chk("rst_pre_vld", 32'(rsp_vld), 32'd1);
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk("rst_mid_vld_now", 32'(rsp_vld), 32'd0);
        @(negedge clk);
        chk("rst_mid_vld_neg", 32'(rsp_vld), 32'd0);
        cyc();
        rst = 1'b0; rsp_rdy = 1'b1;
        stale = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_vld) stale++;
        end
        chk("rst_no_stale", 32'(stale), 32'd0);
        nacc = 0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            rsp_rdy = 1'b0; rd_vld = 1'b1; rd_addr = AW'(24 + nacc);
            @(negedge clk);
            if (rd_rdy) nacc++;
        end
        chk("rst_credits_full", 32'(nacc), 32'(DEPTH));
        drain(8);

        chk("end_sb_empty", 32'(exp_q.size()), 32'd0);
        chk("no_push_full", 32'(ovf_cnt), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
